// File: rtl/gradient_builder.sv
// Full-image central-difference gradient engine: reads four clamped neighbours per pixel
// from a 2-cycle-latency image BRAM and writes halved x/y differences to two gradient BRAMs.
module gradient_builder #(
   parameter int DIMENSION = 64,
   parameter int BIT_DEPTH = 8
) (
   input  logic                                     clk,
   input  logic                                     rst_in,
   input  logic                                     start,
   output logic [$clog2(DIMENSION*DIMENSION)-1:0]   image_address,
   input  logic [BIT_DEPTH-1:0]                     image_pixel,
   output logic [$clog2(DIMENSION*DIMENSION)-1:0]   grad_address,
   output logic signed [BIT_DEPTH-1:0]              x_grad_out,
   output logic signed [BIT_DEPTH-1:0]              y_grad_out,
   output logic                                     grad_wea,
   output logic                                     busy,
   output logic                                     gradient_done
);

   localparam int AW = $clog2(DIMENSION*DIMENSION);
   localparam int CW = $clog2(DIMENSION);
   localparam logic [CW-1:0] ZERO_C = '0;
   localparam logic [CW-1:0] ONE_C  = CW'(1);
   localparam logic [CW-1:0] MAX_C  = CW'(DIMENSION-1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      WRITE = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t                      r_state, w_next_state;
   logic [2:0]                  r_phase, w_next_phase;
   logic [CW-1:0]               r_x, r_y, w_next_x, w_next_y;
   logic [BIT_DEPTH-1:0]        r_left, r_right, r_up;
   logic [AW-1:0]               w_next_image_address, w_next_grad_address;
   logic signed [BIT_DEPTH-1:0] w_next_x_grad, w_next_y_grad;
   logic                        w_next_wea, w_next_busy, w_next_done;

   // Phase 0..3 select left, right, up, down; coordinates clamp at the image border.
   function automatic logic [AW-1:0] neighbour_addr(input logic [CW-1:0] x,
                                                    input logic [CW-1:0] y,
                                                    input logic [2:0]    phase);
      logic [CW-1:0] nx;
      logic [CW-1:0] ny;
      nx = x;
      ny = y;
      case (phase)
         3'd0:    nx = (x == ZERO_C) ? x : x - ONE_C;
         3'd1:    nx = (x == MAX_C)  ? x : x + ONE_C;
         3'd2:    ny = (y == ZERO_C) ? y : y - ONE_C;
         3'd3:    ny = (y == MAX_C)  ? y : y + ONE_C;
         default: begin
            nx = x;
            ny = y;
         end
      endcase
      return {ny, nx};
   endfunction

   // One extra bit holds the full difference; the halving shift brings it back in range.
   function automatic logic signed [BIT_DEPTH-1:0] half_diff(input logic [BIT_DEPTH-1:0] a,
                                                             input logic [BIT_DEPTH-1:0] b);
      logic signed [BIT_DEPTH:0] diff;
      diff = $signed({1'b0, a}) - $signed({1'b0, b});
      diff = diff >>> 1;
      return $signed(diff[BIT_DEPTH-1:0]);
   endfunction

   // Next-state, pixel walk and next values of every registered output.
   always_comb begin
      w_next_state         = r_state;
      w_next_phase         = r_phase;
      w_next_x             = r_x;
      w_next_y             = r_y;
      w_next_image_address = image_address;
      w_next_grad_address  = grad_address;
      w_next_x_grad        = x_grad_out;
      w_next_y_grad        = y_grad_out;

      case (r_state)
         IDLE: begin
            if (start) begin
               w_next_state = FETCH;
               w_next_phase = 3'd0;
               w_next_x     = ZERO_C;
               w_next_y     = ZERO_C;
            end else begin
               w_next_state = IDLE;
            end
         end
         FETCH: begin
            if (r_phase == 3'd5) begin
               w_next_state = WRITE;
               w_next_phase = 3'd0;
            end else begin
               w_next_phase = r_phase + 3'd1;
            end
         end
         WRITE: begin
            if ((r_x == MAX_C) && (r_y == MAX_C)) begin
               w_next_state = DONE;
            end else begin
               w_next_state = FETCH;
               w_next_phase = 3'd0;
               if (r_x == MAX_C) begin
                  w_next_x = ZERO_C;
                  w_next_y = r_y + ONE_C;
               end else begin
                  w_next_x = r_x + ONE_C;
               end
            end
         end
         DONE:    w_next_state = IDLE;
         default: w_next_state = IDLE;
      endcase

      if ((w_next_state == FETCH) && (w_next_phase < 3'd4)) begin
         w_next_image_address = neighbour_addr(w_next_x, w_next_y, w_next_phase);
      end else begin
         w_next_image_address = image_address;
      end

      // The down neighbour arrives on the last fetch cycle and is used straight from the bus.
      if ((r_state == FETCH) && (r_phase == 3'd5)) begin
         w_next_grad_address = {r_y, r_x};
         w_next_x_grad       = half_diff(r_right, r_left);
         w_next_y_grad       = half_diff(image_pixel, r_up);
      end else begin
         w_next_grad_address = grad_address;
      end

      w_next_wea  = (w_next_state == WRITE);
      w_next_busy = (w_next_state == FETCH) || (w_next_state == WRITE);
      w_next_done = (w_next_state == DONE);
   end

   // State, pixel position and registered outputs.
   always_ff @(posedge clk or negedge rst_in) begin
      if (!rst_in) begin
         r_state       <= IDLE;
         r_phase       <= 3'd0;
         r_x           <= ZERO_C;
         r_y           <= ZERO_C;
         image_address <= '0;
         grad_address  <= '0;
         x_grad_out    <= '0;
         y_grad_out    <= '0;
         grad_wea      <= 1'b0;
         busy          <= 1'b0;
         gradient_done <= 1'b0;
      end else begin
         r_state       <= w_next_state;
         r_phase       <= w_next_phase;
         r_x           <= w_next_x;
         r_y           <= w_next_y;
         image_address <= w_next_image_address;
         grad_address  <= w_next_grad_address;
         x_grad_out    <= w_next_x_grad;
         y_grad_out    <= w_next_y_grad;
         grad_wea      <= w_next_wea;
         busy          <= w_next_busy;
         gradient_done <= w_next_done;
      end
   end

   // Neighbour capture two cycles after each issued address.
   always_ff @(posedge clk or negedge rst_in) begin
      if (!rst_in) begin
         r_left  <= '0;
         r_right <= '0;
         r_up    <= '0;
      end else if (r_state == FETCH) begin
         case (r_phase)
            3'd2:    r_left  <= image_pixel;
            3'd3:    r_right <= image_pixel;
            3'd4:    r_up    <= image_pixel;
            default: r_left  <= r_left;
         endcase
      end else begin
         r_left <= r_left;
      end
   end

endmodule

// File: doc/gradient_builder.md
GRADIENT_BUILDER -- requirements
Module: gradient_builder

Interface
REQ-001 The module SHALL have parameter DIMENSION, default 64, giving the image width and height in pixels (power of two, at least 4).
REQ-002 The module SHALL have parameter BIT_DEPTH, default 8, giving the unsigned pixel width and the signed gradient width.
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 The module SHALL have port rst_in, input, 1 bit: asynchronous, active-low reset.
REQ-005 The module SHALL have port start, input, 1 bit: begin one full-image gradient pass.
REQ-006 The module SHALL have port image_address, output, $clog2(DIMENSION*DIMENSION) bits: image BRAM read address.
REQ-007 The module SHALL have port image_pixel, input, BIT_DEPTH bits: unsigned image BRAM read data, valid 2 cycles after its address.
REQ-008 The module SHALL have port grad_address, output, $clog2(DIMENSION*DIMENSION) bits: shared write address for both gradient BRAMs.
REQ-009 The module SHALL have port x_grad_out, output, signed BIT_DEPTH bits: x gradient write data.
REQ-010 The module SHALL have port y_grad_out, output, signed BIT_DEPTH bits: y gradient write data.
REQ-011 The module SHALL have port grad_wea, output, 1 bit: write enable for both gradient BRAMs.
REQ-012 The module SHALL have port busy, output, 1 bit: high from the accepted start until done.
REQ-013 The module SHALL have port gradient_done, output, 1 bit: single-cycle completion pulse.

Function
REQ-014 Pixels SHALL be processed in raster order, with address = y*DIMENSION + x, x fastest, from (0,0) to (DIMENSION-1, DIMENSION-1).
REQ-015 The FSM SHALL have states IDLE, FETCH, WRITE and DONE.
REQ-016 In IDLE, a start while busy=0 SHALL move the FSM to FETCH for pixel 0 on the next edge.
REQ-017 Any start while busy=1 SHALL be ignored.
REQ-018 FETCH SHALL issue 4 image addresses on consecutive cycles, in this order: left (x-1,y), right (x+1,y), up (x,y-1), down (x,y+1).
REQ-019 Each of the 4 FETCH reads SHALL be captured exactly 2 cycles after its address is issued.
REQ-020 Neighbour coordinates SHALL be clamped to [0, DIMENSION-1] (edge replication): x=0 uses left=(0,y); x=DIMENSION-1 uses right=(DIMENSION-1,y); the same rule applies to y.
REQ-021 x_grad SHALL equal (right - left) computed at BIT_DEPTH+1 signed bits, then arithmetic-shifted right by 1 and truncated to BIT_DEPTH bits; y_grad SHALL equal (down - up) computed the same way.
REQ-022 The x_grad and y_grad results SHALL span -2^(BIT_DEPTH-1) to 2^(BIT_DEPTH-1)-1 with no saturation logic needed.
REQ-023 WRITE SHALL hold grad_wea=1 for exactly one cycle, with grad_address equal to the current pixel address and both gradients valid in that same cycle.
REQ-024 Each pixel SHALL take exactly 7 cycles: issue cycles 0-3, captures on cycles 2-5, write on cycle 6.
REQ-025 After the write for the last pixel, the FSM SHALL enter DONE for exactly one cycle.
REQ-026 In DONE, gradient_done SHALL be 1 and busy SHALL be 0, and the FSM SHALL return to IDLE on the next edge.
REQ-027 The first grad_wea SHALL occur 7 cycles after the start edge.
REQ-028 gradient_done SHALL occur 7*DIMENSION*DIMENSION+1 cycles after the start edge.
REQ-029 grad_wea SHALL be 0 in every cycle outside WRITE.
REQ-030 A start sampled in the same cycle as gradient_done SHALL be ignored.
REQ-031 x_grad_out, y_grad_out and grad_address SHALL hold their last written values while idle.

Reset
REQ-032 While rst_in=0, the FSM SHALL be IDLE, and image_address, grad_address, x_grad_out, y_grad_out, grad_wea, busy and gradient_done SHALL all be 0, independent of clk.
REQ-033 A reset asserted mid-pass SHALL abort immediately, with no further writes and no gradient_done.
REQ-034 After rst_in rises, the next start SHALL begin a fresh pass at pixel 0.

Verification (DIMENSION=8, BIT_DEPTH=8, 2-cycle BRAM model)
REQ-035 Constant image of 100, start -> 64 writes, all x_grad=0 and y_grad=0; gradient_done at cycle 449 after start; busy high for cycles 1-448.
REQ-036 Horizontal ramp p=4x -> interior x_grad=4; x=0 and x=7 give x_grad=2; all y_grad=0; addresses written 0..63 in order.
REQ-037 Extremes: column 7 at 255 and the rest 0 -> pixel (6,y) x_grad=127; column 5 at 255 and the rest 0 -> pixel (6,y) x_grad=-128; vertical analogues for y_grad.
REQ-038 start pulsed again at cycle 100 and at the gradient_done cycle -> ignored: exactly 64 writes and one gradient_done.
REQ-039 rst_in low at cycle 200 mid-pass -> all outputs 0 asynchronously; no write and no gradient_done afterwards; a new start gives a complete, correct pass.
REQ-040 Every grad_wea pulse is exactly 1 cycle wide with a 7-cycle spacing; image_address never exceeds 63.
